// File: rtl/pipe_stage_regs_pkg.sv
// rtl/pipe_stage_regs_pkg.sv - shared constants, field ranges and stage triple type
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000000;
  localparam logic [31:0] PC_RESET  = 32'h00003000;
  localparam logic [31:0] PC8_OFFS  = 32'd8;

  // Register specifier field positions inside an instruction word
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  // One pipeline stage: instruction, link value and bubble flag move together
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc8;
    logic        valid;
  } stage_t;

  localparam stage_t BUBBLE = '{ir: NOP_INSTR, pc8: 32'h00000000, valid: 1'b0};

  function automatic logic [4:0] instr_rs(input logic [31:0] ir);
    return ir[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] instr_rt(input logic [31:0] ir);
    return ir[RT_HI:RT_LO];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [31:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

endpackage

// File: rtl/pipe_stage_regs_if.sv
// rtl/pipe_stage_regs_if.sv - fetch/hazard side bundle of the pipeline stage registers
interface pipe_stage_regs_if;

  logic        stall;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic [31:0] IR_D, IR_E, IR_M, IR_W;
  logic [31:0] PC8_D, PC8_E, PC8_M, PC8_W;
  logic        valid_D, valid_E, valid_M, valid_W;
  logic        pc_en;
  logic [31:0] stall_cnt;
  logic [31:0] retire_cnt;

  // Driven by fetch and hazard logic
  modport master (
    output stall, instr_F, pc_F,
    input  IR_D, IR_E, IR_M, IR_W,
    input  PC8_D, PC8_E, PC8_M, PC8_W,
    input  valid_D, valid_E, valid_M, valid_W,
    input  pc_en, stall_cnt, retire_cnt
  );

  // Implemented by the stage register block
  modport slave (
    input  stall, instr_F, pc_F,
    output IR_D, IR_E, IR_M, IR_W,
    output PC8_D, PC8_E, PC8_M, PC8_W,
    output valid_D, valid_E, valid_M, valid_W,
    output pc_en, stall_cnt, retire_cnt
  );

endinterface

// File: rtl/pipe_stage_regs_stage_reg.sv
// rtl/pipe_stage_regs_stage_reg.sv - one atomic IR/PC8/valid stage register
module stage_reg
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   clr,
  input  stage_t stage_d,
  output stage_t stage_q
);

  stage_t stage_q_r;

  // Bubble load wins over hold so a stalled stage can still be flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q_r <= BUBBLE;
    end else if (clr) begin
      stage_q_r <= BUBBLE;
    end else if (en) begin
      stage_q_r <= stage_d;
    end
  end

  assign stage_q = stage_q_r;

endmodule

// File: rtl/pipe_stage_regs.sv
// rtl/pipe_stage_regs.sv - D/E/M/W stage registers with stall, bubble insertion and counters
module pipe_stage_regs
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  pipe_stage_regs_if.slave bus
);

  stage_t fetch_d;
  stage_t d_q, e_q, m_q, w_q;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Incoming fetch triple; instruction value never affects validity
  always_comb begin
    fetch_d       = BUBBLE;
    fetch_d.ir    = bus.instr_F;
    fetch_d.pc8   = bus.pc_F + PC8_OFFS;
    fetch_d.valid = 1'b1;
  end

  stage_reg u_stage_d (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (~bus.stall),
    .clr     (1'b0),
    .stage_d (fetch_d),
    .stage_q (d_q)
  );

  stage_reg u_stage_e (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (1'b1),
    .clr     (bus.stall),
    .stage_d (d_q),
    .stage_q (e_q)
  );

  stage_reg u_stage_m (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (1'b1),
    .clr     (1'b0),
    .stage_d (e_q),
    .stage_q (m_q)
  );

  stage_reg u_stage_w (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (1'b1),
    .clr     (1'b0),
    .stage_d (m_q),
    .stage_q (w_q)
  );

  // Next counter values; retire looks at W before the edge moves it on
  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, bus.stall};
    retire_cnt_d = retire_cnt_q + {31'd0, w_q.valid};
  end

  // Free-running wrap-around counters, cleared by reset only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.pc_en      = ~bus.stall;
  assign bus.IR_D       = d_q.ir;
  assign bus.IR_E       = e_q.ir;
  assign bus.IR_M       = m_q.ir;
  assign bus.IR_W       = w_q.ir;
  assign bus.PC8_D      = d_q.pc8;
  assign bus.PC8_E      = e_q.pc8;
  assign bus.PC8_M      = m_q.pc8;
  assign bus.PC8_W      = w_q.pc8;
  assign bus.valid_D    = d_q.valid;
  assign bus.valid_E    = e_q.valid;
  assign bus.valid_M    = m_q.valid;
  assign bus.valid_W    = w_q.valid;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: doc/pipe_stage_regs.md
PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  pipeline stall request from the hazard unit, sampled at clk rise.
REQ-005 instr_F  input  32  instruction fetched this cycle.
REQ-006 pc_F  input  32  PC of instr_F.
REQ-007 IR_D, IR_E, IR_M, IR_W  output  32 each  per-stage instruction, fed to the hazard unit.
REQ-008 PC8_D, PC8_E, PC8_M, PC8_W  output  32 each  per-stage PC+8, used as link value.
REQ-009 valid_D, valid_E, valid_M, valid_W  output  1 each  stage holds a real instruction, not a bubble.
REQ-010 pc_en  output  1  PC register write enable.
REQ-011 stall_cnt  output  32  count of stalled cycles.
REQ-012 retire_cnt  output  32  count of valid instructions leaving W.

Function
REQ-013 pc_en SHALL equal ~stall combinationally, with no register delay.
REQ-014 When stall=0 at a clk rise, D SHALL load {instr_F, pc_F+8, valid=1}, and E<-D, M<-E, W<-M SHALL load in the same edge.
REQ-015 When stall=1 at a clk rise, D SHALL hold its value, E SHALL load a bubble (IR=NOP_INSTR, PC8=0, valid=0), and M<-E, W<-M SHALL still advance.
REQ-016 Each stage SHALL carry IR, PC8 and valid as one atomic triple; no field may advance without the others.
REQ-017 PC+8 SHALL be computed as 32-bit unsigned addition, wrapping modulo 2^32 (pc_F=0xFFFFFFFC gives 0x00000004).
REQ-018 An instruction word of 0x00000000 from fetch SHALL be treated as valid; validity is decided only by bubble insertion and reset.
REQ-019 stall_cnt SHALL increment by 1 on each clk rise with stall=1, wrapping from 0xFFFFFFFF to 0.
REQ-020 retire_cnt SHALL increment by 1 on each clk rise where valid_W=1 before the edge, wrapping from 0xFFFFFFFF to 0.
REQ-021 Back-to-back stall cycles SHALL insert one bubble per cycle while D keeps holding the same instruction.
REQ-022 A stall in the first cycle after reset SHALL keep D at its reset bubble and insert a bubble into E.
REQ-023 Counter increments and stage updates on the same edge SHALL all take effect on that edge.

Reset
REQ-024 While rst_n=0, all IR_* SHALL be NOP_INSTR, all PC8_* 0, all valid_* 0, stall_cnt 0 and retire_cnt 0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL clear the block in the same instant; in-flight instructions are discarded and not counted as retired.
REQ-026 The first clk rise after rst_n deasserts SHALL be treated as a normal cycle per REQ-014/015.

Structure
REQ-027 A shared package pipe_pkg SHALL hold NOP_INSTR=32'h00000000, PC_RESET=32'h00003000, the instruction field ranges rs/rt/rd, and the stage-triple record type.
REQ-028 One sub-module, stage_reg, SHALL implement a single triple register with en (hold when 0) and clr (load bubble), and SHALL be instantiated four times.
REQ-029 D SHALL connect as en=~stall, clr=0; E as en=1, clr=stall; M and W as en=1, clr=0.
REQ-030 Counters SHALL live in the top level, not in stage_reg.

Verification
REQ-031 Reset then no stall; instr_F=0x3C011234 at pc_F=0x3000 -> IR_D=0x3C011234, PC8_D=0x3008 after edge 1; IR_W=0x3C011234 after edge 4; retire_cnt=1 after edge 5.
REQ-032 lw at 0x3000, dependent addu at 0x3004; stall=1 for one cycle at edge 3 -> IR_D holds the addu, IR_E=0 with valid_E=0, pc_en=0 during that cycle; retire_cnt counts 2 instructions, not the bubble.
REQ-033 stall=1 for 3 consecutive cycles -> stall_cnt=3, three bubbles reach W with valid_W=0, D unchanged throughout.
REQ-034 stall_cnt forced near wrap (0xFFFFFFFF) with one stall cycle -> 0x00000000; pc_F=0xFFFFFFFC -> PC8_D=0x00000004.
REQ-035 rst_n pulsed low between clock edges while 4 stages are valid -> all outputs cleared immediately, retire_cnt=0, no spurious increment on the next edge.
REQ-036 stall=1 on the first edge after reset -> valid_D=0, valid_E=0, stall_cnt=1.
